// File: rtl/pss_demapper.sv
// Purpose  : PSS subcarrier demapper; pulls the 63 occupied bins out of a 128-bin FFT frame in ZC order.
// Latency  : first output beat 1 cycle after the last input bin is accepted.
// Backpress: ready_out low for the whole drain; output holds data/sop/eop stable while ready_in is low.
//
// Optional feature macro: PSS_ENERGY_EN (per-frame |x|^2 energy accumulator).
// When PSS_ENERGY_EN is undefined, energy_out and energy_valid are tied to 0.
//
// Ports:
//   clk          clock
//   rst          synchronous active-low reset
//   data_in      input FFT bin, {imag, real}, signed DW-bit components
//   valid_in     input beat valid
//   sop_in       marks data_in as bin 0 of a frame
//   ready_out    block can accept an input beat (FILL state only)
//   data_out     extracted subcarrier, same packing as data_in
//   valid_out    output beat valid (DRAIN state only)
//   ready_in     downstream ready
//   sop_out      high with element k = 0
//   eop_out      high with element k = SEQ_LEN-1
//   frame_err    one-cycle pulse when a partial frame is aborted by sop_in
//   energy_out   sum of re^2+im^2 over the last drained frame
//   energy_valid one-cycle pulse when energy_out updates

module pss_demapper #(
  parameter int N_FFT    = 128,
  parameter int SEQ_LEN  = 63,
  parameter int DW       = 16,
  parameter int ENERGY_W = 2*DW+6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*DW-1:0]     data_in,
  input  logic                valid_in,
  input  logic                sop_in,
  output logic                ready_out,
  output logic [2*DW-1:0]     data_out,
  output logic                valid_out,
  input  logic                ready_in,
  output logic                sop_out,
  output logic                eop_out,
  output logic                frame_err,
  output logic [ENERGY_W-1:0] energy_out,
  output logic                energy_valid
);

  localparam int BIN_W      = $clog2(N_FFT);
  localparam int PTR_W      = $clog2(SEQ_LEN);
  localparam int HALF       = (SEQ_LEN-1)/2;
  localparam int LAST_BIN_I = N_FFT-1;
  localparam int LAST_K_I   = SEQ_LEN-1;

  localparam logic [BIN_W-1:0] LAST_BIN = LAST_BIN_I[BIN_W-1:0];
  localparam logic [PTR_W-1:0] LAST_K   = LAST_K_I[PTR_W-1:0];
  localparam logic [BIN_W:0]   HALF_X   = HALF[BIN_W:0];
  localparam logic [BIN_W:0]   NFFT_X   = N_FFT[BIN_W:0];
  localparam logic [BIN_W:0]   SEQ_X    = SEQ_LEN[BIN_W:0];

  typedef enum logic [0:0] {
    S_FILL  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [BIN_W-1:0] r_bin_idx;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             r_frame_err;
  logic [2*DW-1:0]  r_buf [SEQ_LEN];

  logic             w_fill;
  logic             w_drain;
  logic             w_in_acc;
  logic             w_out_acc;
  logic             w_last_k;
  logic             w_eop_acc;
  logic [BIN_W-1:0] w_bin;
  logic [BIN_W:0]   w_addr_sum;
  logic [BIN_W:0]   w_addr;
  logic             w_keep;

  // State decode. Gating with rst forces ready/valid low for the whole time
  // reset is held, including the cycle before the first reset edge lands.
  assign w_fill  = (r_state == S_FILL)  && rst;
  assign w_drain = (r_state == S_DRAIN) && rst;

  assign ready_out = w_fill;
  assign valid_out = w_drain;

  assign w_in_acc  = valid_in && w_fill;
  assign w_out_acc = w_drain && ready_in;
  assign w_last_k  = (r_rd_ptr == LAST_K);
  assign w_eop_acc = w_out_acc && w_last_k;

  assign data_out  = w_drain ? r_buf[r_rd_ptr] : '0;
  assign sop_out   = w_drain && (r_rd_ptr == '0);
  assign eop_out   = w_drain && w_last_k;
  assign frame_err = r_frame_err;

  // Effective bin of the current beat: a sop always restarts the frame at
  // bin 0, whatever the running count says.
  assign w_bin = sop_in ? '0 : r_bin_idx;

  // Undo the transmit mapping: shift by HALF modulo N_FFT so the negative
  // half of the ZC sequence lands at k=0..HALF-1 and the positive half after
  // it. Anything that maps past SEQ_LEN-1 is an unoccupied bin.
  always_comb begin
    w_addr_sum = {1'b0, w_bin} + HALF_X;
    w_addr     = w_addr_sum;
    if (w_addr_sum >= NFFT_X) begin
      w_addr = w_addr_sum - NFFT_X;
    end
    w_keep = (w_addr < SEQ_X);
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL: begin
        if (w_in_acc && (w_bin == LAST_BIN)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_eop_acc) begin
          w_state_nxt = S_FILL;
        end
      end
      default: begin
        w_state_nxt = S_FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counters and the abort flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bin_idx   <= '0;
      r_rd_ptr    <= '0;
      r_frame_err <= 1'b0;
    end else begin
      // A sop in the middle of a frame throws the partial frame away; the
      // buffer slots it filled are simply overwritten by the new frame.
      r_frame_err <= w_in_acc && sop_in && (r_bin_idx != '0);
      if (w_in_acc) begin
        r_bin_idx <= (w_bin == LAST_BIN) ? '0 : (w_bin + BIN_W'(1));
      end
      if (w_out_acc) begin
        r_rd_ptr <= w_last_k ? '0 : (r_rd_ptr + PTR_W'(1));
      end
    end
  end

  // Subcarrier store. No reset needed: the drain only ever runs after a
  // complete frame has rewritten every slot.
  always_ff @(posedge clk) begin
    if (w_in_acc && w_keep) begin
      r_buf[w_addr[PTR_W-1:0]] <= data_in;
    end
  end

`ifdef PSS_ENERGY_EN
  logic signed [DW-1:0]   w_re;
  logic signed [DW-1:0]   w_im;
  logic signed [2*DW-1:0] w_re_sq;
  logic signed [2*DW-1:0] w_im_sq;
  logic [ENERGY_W-1:0]    w_beat_e;
  logic [ENERGY_W-1:0]    w_acc_sum;
  logic [ENERGY_W-1:0]    r_acc;
  logic [ENERGY_W-1:0]    r_energy;
  logic                   r_energy_vld;

  assign w_re = data_out[DW-1:0];
  assign w_im = data_out[2*DW-1:DW];

  // Squares are never negative and (-2^(DW-1))^2 still fits in 2*DW signed
  // bits, so zero-extending into the accumulator width is safe.
  assign w_re_sq   = w_re * w_re;
  assign w_im_sq   = w_im * w_im;
  assign w_beat_e  = {{(ENERGY_W-2*DW){1'b0}}, w_re_sq}
                   + {{(ENERGY_W-2*DW){1'b0}}, w_im_sq};
  assign w_acc_sum = r_acc + w_beat_e;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc        <= '0;
      r_energy     <= '0;
      r_energy_vld <= 1'b0;
    end else begin
      r_energy_vld <= w_eop_acc;
      if (w_out_acc) begin
        if (w_last_k) begin
          // Final beat: publish the total and start the next frame from 0.
          r_energy <= w_acc_sum;
          r_acc    <= '0;
        end else begin
          r_acc <= w_acc_sum;
        end
      end
    end
  end

  assign energy_out   = r_energy;
  assign energy_valid = r_energy_vld;
`else
  assign energy_out   = '0;
  assign energy_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pss_demapper.sv
// Directed bench for pss_demapper: full frames with and without backpressure,
// input held valid during drain, mid-frame sop abort, reset mid-drain and,
// when PSS_ENERGY_EN is defined, the frame energy output.

module tb_pss_demapper;

  localparam int N_FFT    = 128;
  localparam int SEQ_LEN  = 63;
  localparam int DW       = 16;
  localparam int ENERGY_W = 2*DW+6;
  localparam int HALF     = (SEQ_LEN-1)/2;

  logic                clk = 1'b0;
  logic                rst;
  logic [2*DW-1:0]     data_in;
  logic                valid_in;
  logic                sop_in;
  logic                ready_out;
  logic [2*DW-1:0]     data_out;
  logic                valid_out;
  logic                ready_in;
  logic                sop_out;
  logic                eop_out;
  logic                frame_err;
  logic [ENERGY_W-1:0] energy_out;
  logic                energy_valid;

  int checks   = 0;
  int failures = 0;

  // Frame content generator state.
  int          g_base      = 0;
  bit          g_const     = 1'b0;
  logic [31:0] g_const_dat = '0;

  always #5 clk = ~clk;

  pss_demapper #(
    .N_FFT(N_FFT), .SEQ_LEN(SEQ_LEN), .DW(DW), .ENERGY_W(ENERGY_W)
  ) dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .valid_in(valid_in), .sop_in(sop_in), .ready_out(ready_out),
    .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
    .sop_out(sop_out), .eop_out(eop_out), .frame_err(frame_err),
    .energy_out(energy_out), .energy_valid(energy_valid)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int bin);
    logic [15:0] v;
    v = 16'(g_base + bin);
    return g_const ? g_const_dat : {v, v};
  endfunction

  // ZC element k comes from bin 97+k for k<31, otherwise bin k-31.
  function automatic int exp_bin(input int k);
    return (k < HALF) ? (N_FFT - HALF + k) : (k - HALF);
  endfunction

  function automatic logic [63:0] energy_model();
    longint acc;
    longint re;
    longint im;
    logic [31:0] d;
    acc = 0;
    for (int k = 0; k < SEQ_LEN; k++) begin
      d  = pat(exp_bin(k));
      re = $signed(d[15:0]);
      im = $signed(d[31:16]);
      acc += re*re + im*im;
    end
    return 64'(acc);
  endfunction

  // Push nbins consecutive bins starting at bin 0 (sop on the first).
  task automatic feed(input int nbins, input bit err_exp);
    for (int b = 0; b < nbins; b++) begin
      @(negedge clk);
      chk("ready_out_fill", ready_out, 1);
      chk("frame_err", frame_err, (b == 1) && err_exp);
      valid_in = 1'b1;
      sop_in   = (b == 0);
      data_in  = pat(b);
      @(posedge clk);
    end
    @(negedge clk);
    valid_in = 1'b0;
    sop_in   = 1'b0;
    chk("valid_after_last_bin", valid_out, nbins == N_FFT);
  endtask

  // Collect nbeats output beats; mode 1 drives ready_in 1,0,0,1,0,0,...
  task automatic drain(input int nbeats, input int mode);
    int k;
    int cyc;
    k   = 0;
    cyc = 0;
    while (k < nbeats && cyc < 1000) begin
      @(negedge clk);
      chk("valid_out_drain", valid_out, 1);
      chk("ready_out_drain", ready_out, 0);
      chk("data_out", data_out, pat(exp_bin(k)));
      chk("sop_out", sop_out, k == 0);
      chk("eop_out", eop_out, k == SEQ_LEN-1);
      ready_in = (mode == 0) || (cyc % 3 == 0);
      @(posedge clk);
      if (ready_in) k++;
      cyc++;
    end
    chk("drain_beats", k, nbeats);
  endtask

  task automatic post_drain();
    @(negedge clk);
    chk("valid_after_eop", valid_out, 0);
    chk("ready_after_eop", ready_out, 1);
`ifdef PSS_ENERGY_EN
    chk("energy_valid_pulse", energy_valid, 1);
    chk("energy_out_model", energy_out, energy_model());
`else
    chk("energy_valid_tied", energy_valid, 0);
    chk("energy_out_tied", energy_out, 0);
`endif
    valid_in = 1'b0;
    sop_in   = 1'b0;
    ready_in = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    valid_in = 1'b0;
    sop_in   = 1'b0;
    data_in  = '0;
    ready_in = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready_out", ready_out, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_sop_out", sop_out, 0);
    chk("rst_eop_out", eop_out, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_energy_out", energy_out, 0);
    chk("rst_energy_valid", energy_valid, 0);
    rst = 1'b1;
    #1;
    chk("ready_after_release", ready_out, 1);

    // Ramp frame, no backpressure.
    g_base = 0;
    feed(N_FFT, 1'b0);
    drain(SEQ_LEN, 0);
    post_drain();

    // Same frame, ready_in toggling 1,0,0.
    g_base = 0;
    feed(N_FFT, 1'b0);
    drain(SEQ_LEN, 1);
    post_drain();

    // valid_in held high with junk during drain, then an immediate next frame.
    g_base = 16'h100;
    feed(N_FFT, 1'b0);
    valid_in = 1'b1;
    sop_in   = 1'b1;
    data_in  = 32'hDEAD_BEEF;
    drain(SEQ_LEN, 0);
    post_drain();
    g_base = 16'h1000;
    feed(N_FFT, 1'b0);
    drain(SEQ_LEN, 0);
    post_drain();

    // Abort at bin index 50; second frame must come out intact.
    g_base = 16'h200;
    feed(50, 1'b0);
    g_base = 16'h300;
    feed(N_FFT, 1'b1);
    drain(SEQ_LEN, 0);
    post_drain();

    // Reset during drain beat 20.
    g_base = 16'h400;
    feed(N_FFT, 1'b0);
    drain(20, 0);
    @(negedge clk);
    rst      = 1'b0;
    ready_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid_out", valid_out, 0);
    chk("midrst_ready_out", ready_out, 0);
    chk("midrst_data_out", data_out, 0);
    chk("midrst_sop_out", sop_out, 0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ready_out_hold", ready_out, 0);
    rst = 1'b1;
    #1;
    chk("midrst_ready_release", ready_out, 1);
    g_base = 16'h500;
    feed(N_FFT, 1'b0);
    drain(SEQ_LEN, 0);
    post_drain();

`ifdef PSS_ENERGY_EN
    g_const     = 1'b1;
    g_const_dat = 32'h0001_0001;
    feed(N_FFT, 1'b0);
    drain(SEQ_LEN, 0);
    post_drain();
    chk("energy_ones", energy_out, 64'd126);
    @(negedge clk);
    chk("energy_valid_one_cycle", energy_valid, 0);

    g_const_dat = 32'h0000_8000;
    feed(N_FFT, 1'b0);
    drain(SEQ_LEN, 0);
    post_drain();
    chk("energy_min_real", energy_out, 64'd63 << 30);
    g_const = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
